// File: rtl/debounce_sync_edge.sv
// debounce_sync_edge: two-flop synchroniser followed by a stability-count
// qualifier. Produces a clean registered level q plus one-cycle rise/fall
// strobes aligned with the first cycle of the new level.
module debounce_sync_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CHK_LO = 2'd3
  } state_t;

  // Final count value: reaching it with one more matching sample accepts the level.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [1:0]       r_sync;   // [0] = s1, [1] = s2
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q;
  logic             r_rise;
  logic             r_fall;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_q_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_sync;

  assign w_sync = r_sync[1];

  // Two-flop synchroniser; only the second stage feeds the qualifier.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], d_in};
  end

  // Next-state, counter and output decode; strobes default low so they last one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      ST_LOW: begin
        if (w_sync) begin
          w_state_nxt = ST_CHK_HI;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_CHK_HI: begin
        if (!w_sync) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = ST_CHK_LO;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_CHK_LO: begin
        if (w_sync) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
        w_q_nxt     = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset wins over any pending qualify edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = (r_state == ST_CHK_HI) || (r_state == ST_CHK_LO);

endmodule

// File: tb/tb_debounce_sync_edge.sv
// Directed bench for debounce_sync_edge with STABLE_CYCLES=4.
module tb_debounce_sync_edge;

  logic clk;
  logic rst;
  logic d_in;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  int n_chk;
  int n_err;
  int n_rise;

  debounce_sync_edge #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %b exp %b", tag, $time, obs, exp);
    end
  endtask

  // Drive d_in on the falling edge, then sample just after the next rising edge.
  task automatic tick(input logic v);
    @(negedge clk);
    d_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] pat;
    n_chk  = 0;
    n_err  = 0;
    n_rise = 0;
    rst    = 1'b1;
    d_in   = 1'b1;

    // Reset hold with d_in high.
    for (int k = 1; k <= 3; k++) begin
      tick(1'b1);
      chk("rst_q", q, 1'b0);
      chk("rst_rise", rise, 1'b0);
      chk("rst_fall", fall, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) tick(1'b0);
    chk("idle_q", q, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Clean rise: qualify window on ticks 3..5, q and rise on tick 6.
    for (int k = 1; k <= 12; k++) begin
      tick(1'b1);
      chk("rise_q", q, k >= 6);
      chk("rise_busy", busy, k >= 3 && k <= 5);
      chk("rise_strb", rise, k == 6);
      chk("rise_fall", fall, 1'b0);
    end

    // Clean fall: mirror image.
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0);
      chk("fall_q", q, k < 6);
      chk("fall_busy", busy, k >= 3 && k <= 5);
      chk("fall_strb", fall, k == 6);
      chk("fall_rise", rise, 1'b0);
    end

    // Glitch: two high samples only reach cnt=2 before the low arrives.
    for (int k = 1; k <= 8; k++) begin
      tick(k <= 2);
      chk("glt_q", q, 1'b0);
      chk("glt_busy", busy, k == 3 || k == 4);
      chk("glt_rise", rise, 1'b0);
    end

    // Bounce 1,0,1,1,0,1 then steady 1; q rises 6 edges after the last 0->1.
    pat = 6'b101101;
    for (int k = 1; k <= 16; k++) begin
      tick(k <= 6 ? pat[k-1] : 1'b1);
      if (rise) n_rise++;
      chk("bnc_q", q, k >= 11);
      chk("bnc_busy", busy, k == 3 || k == 5 || k == 6 || (k >= 8 && k <= 10));
      chk("bnc_rise", rise, k == 11);
      chk("bnc_fall", fall, 1'b0);
    end
    chk("bnc_nrise", n_rise == 1, 1'b1);

    // Return low, then reset in the middle of qualifying a rise.
    for (int k = 1; k <= 8; k++) tick(1'b0);
    chk("pre6_q", q, 1'b0);
    for (int k = 1; k <= 4; k++) tick(1'b1);
    chk("pre6_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rsync_busy", busy, 1'b1);
    chk("rsync_q", q, 1'b0);
    @(posedge clk);
    #1;
    chk("rmid_q", q, 1'b0);
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_rise", rise, 1'b0);
    chk("rmid_fall", fall, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1);
      chk("post_q", q, k >= 6);
      chk("post_busy", busy, k >= 3 && k <= 5);
      chk("post_rise", rise, k == 6);
      chk("post_fall", fall, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
